// File: rtl/qspim_wb_reg_bridge.sv
// Wishbone classic slave to held register-bus request bridge.
// Both sides are registered; responses are single-cycle ack or err pulses.
module qspim_wb_reg_bridge #(
  parameter int unsigned AW      = 24,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [3:0]    reg_be,
  output logic [31:0]   reg_wdata,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_ack
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [TO_W-1:0] TimeoutLast = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            cs_q, cs_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            adr_ok;

  // Any set bit above the register address window is out of range.
  assign adr_ok = (wbs_adr_i >> AW) == 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cs_d    = cs_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (adr_ok) begin
            addr_d  = wbs_adr_i[AW-1:0];
            wr_d    = wbs_we_i;
            be_d    = wbs_sel_i;
            wdata_d = wbs_dat_i;
            cs_d    = 1'b1;
            cnt_d   = '0;
            state_d = StReq;
          end else begin
            err_d   = 1'b1;
            dat_d   = 32'd0;
            state_d = StResp;
          end
        end
      end
      StReq: begin
        if (!wbs_cyc_i) begin
          // Master abandoned the cycle: drop the request silently.
          cs_d    = 1'b0;
          state_d = StIdle;
        end else if (reg_ack) begin
          cs_d    = 1'b0;
          ack_d   = 1'b1;
          dat_d   = wr_q ? 32'd0 : reg_rdata;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          cs_d    = 1'b0;
          err_d   = 1'b1;
          dat_d   = 32'd0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign reg_cs    = cs_q;
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_be    = be_q;
  assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_qspim_wb_reg_bridge.sv
// Bench for qspim_wb_reg_bridge: directed scenarios with a response scoreboard
// that checks every ack/err pulse against the expectation queued at issue time.
module tb_qspim_wb_reg_bridge;

  localparam int unsigned AW      = 24;
  localparam int unsigned TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [31:0]   adr, wdat;
  logic [3:0]    sel;
  logic [31:0]   wbs_dat_o;
  logic          wbs_ack_o, wbs_err_o;
  logic          reg_cs, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [3:0]    reg_be;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          reg_ack;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cycle    = 0;
  int    last_resp_cycle = 0;

  qspim_wb_reg_bridge #(.AW(AW), .TO_W(8), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_adr_i (adr),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (wdat),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_be    (reg_be),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) begin
        last_resp_cycle = cycle;
        checks++;
        if (wbs_ack_o && wbs_err_o) begin
          failures++;
          $display("FAIL resp_exclusive: ack=%b err=%b required not both", wbs_ack_o, wbs_err_o);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: ack=%b err=%b dat=%h required no response",
                   wbs_ack_o, wbs_err_o, wbs_dat_o);
        end else begin
          e = exp_q.pop_front();
          if ({wbs_ack_o, wbs_err_o, wbs_dat_o} !== {~e.err, e.err, e.dat}) begin
            failures++;
            $display("FAIL resp_sb: ack=%b err=%b dat=%h required ack=%b err=%b dat=%h",
                     wbs_ack_o, wbs_err_o, wbs_dat_o, ~e.err, e.err, e.dat);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic err, input logic [31:0] dat);
    resp_t e;
    e.err = err;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d);
    cyc  = 1'b1;
    stb  = 1'b1;
    adr  = a;
    we   = w;
    sel  = s;
    wdat = d;
  endtask

  task automatic idle_bus();
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({wbs_dat_o, wbs_ack_o, wbs_err_o, reg_cs, reg_wr, reg_addr, reg_be, reg_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: dat=%h ack=%b err=%b cs=%b wr=%b addr=%h be=%h wdata=%h required all 0",
               wbs_dat_o, wbs_ack_o, wbs_err_o, reg_cs, reg_wr, reg_addr, reg_be, reg_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    push_exp(1'b0, 32'd0);
    reg_rdata = 32'hDEAD_BEEF;
    drive(32'h0000_0010, 1'b1, 4'hF, 32'hA5A5_1234);
    @(negedge clk);
    checks++;
    if ({reg_cs, reg_wr, reg_addr, reg_be, reg_wdata} !== {1'b1, 1'b1, 24'h000010, 4'hF, 32'hA5A5_1234}) begin
      failures++;
      $display("FAIL write_req: cs=%b wr=%b addr=%h be=%h wdata=%h required 1 1 000010 f a5a51234",
               reg_cs, reg_wr, reg_addr, reg_be, reg_wdata);
    end
    @(negedge clk);
    checks++;
    if ({reg_cs, reg_addr, reg_wdata, wbs_ack_o} !== {1'b1, 24'h000010, 32'hA5A5_1234, 1'b0}) begin
      failures++;
      $display("FAIL write_hold: cs=%b addr=%h wdata=%h ack=%b required 1 000010 a5a51234 0",
               reg_cs, reg_addr, reg_wdata, wbs_ack_o);
    end
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    checks++;
    if ({wbs_ack_o, wbs_err_o, reg_cs} !== 3'b100) begin
      failures++;
      $display("FAIL write_ack: ack=%b err=%b cs=%b required 1 0 0", wbs_ack_o, wbs_err_o, reg_cs);
    end
    idle_bus();
    @(negedge clk);
    checks++;
    if ({wbs_ack_o, wbs_err_o} !== 2'b00) begin
      failures++;
      $display("FAIL write_pulse: ack=%b err=%b required 0 0", wbs_ack_o, wbs_err_o);
    end
  endtask

  task automatic test_read();
    push_exp(1'b0, 32'hCAFE_F00D);
    drive(32'h0000_0024, 1'b0, 4'h3, 32'h5555_AAAA);
    @(negedge clk);
    checks++;
    if ({reg_cs, reg_wr, reg_addr, reg_be} !== {1'b1, 1'b0, 24'h000024, 4'h3}) begin
      failures++;
      $display("FAIL read_req: cs=%b wr=%b addr=%h be=%h required 1 0 000024 3",
               reg_cs, reg_wr, reg_addr, reg_be);
    end
    reg_ack   = 1'b1;
    reg_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    reg_ack   = 1'b0;
    reg_rdata = 32'h0;
    checks++;
    if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL read_latency: ack=%b dat=%h required 1 cafef00d", wbs_ack_o, wbs_dat_o);
    end
    idle_bus();
    @(negedge clk);
    checks++;
    if ({wbs_ack_o, wbs_dat_o} !== {1'b0, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL read_dat_hold: ack=%b dat=%h required 0 cafef00d", wbs_ack_o, wbs_dat_o);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit early_drop;
    push_exp(1'b1, 32'd0);
    reg_rdata  = 32'h1234_5678;
    early_drop = 1'b0;
    drive(32'h0000_0008, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    k = 1;
    while (k < 300 && !(wbs_ack_o || wbs_err_o)) begin
      if (!reg_cs) early_drop = 1'b1;
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != TIMEOUT + 1 || early_drop) begin
      failures++;
      $display("FAIL timeout_time: resp at cycle %0d after cs, cs_dropped_early=%b required %0d 0",
               k - 1, early_drop, TIMEOUT);
    end
    checks++;
    if ({wbs_err_o, wbs_ack_o, reg_cs, wbs_dat_o} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL timeout_resp: err=%b ack=%b cs=%b dat=%h required 1 0 0 0",
               wbs_err_o, wbs_ack_o, reg_cs, wbs_dat_o);
    end
    idle_bus();
    reg_rdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    push_exp(1'b1, 32'd0);
    drive(32'h0100_0000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    checks++;
    if ({wbs_err_o, reg_cs} !== 2'b10) begin
      failures++;
      $display("FAIL oor_err: err=%b cs=%b required 1 0", wbs_err_o, reg_cs);
    end
    idle_bus();
    @(negedge clk);
    checks++;
    if ({wbs_err_o, reg_cs} !== 2'b00) begin
      failures++;
      $display("FAIL oor_after: err=%b cs=%b required 0 0", wbs_err_o, reg_cs);
    end
  endtask

  task automatic test_abort();
    reg_rdata = 32'hBAD0_BAD0;
    drive(32'h0000_0030, 1'b1, 4'h1, 32'h0000_00FF);
    repeat (3) @(negedge clk);
    // Third REQ cycle: cycle dropped while the register block acks.
    idle_bus();
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    checks++;
    if ({reg_cs, wbs_ack_o, wbs_err_o} !== 3'b000) begin
      failures++;
      $display("FAIL abort: cs=%b ack=%b err=%b required 0 0 0", reg_cs, wbs_ack_o, wbs_err_o);
    end
    @(negedge clk);
    checks++;
    if ({wbs_ack_o, wbs_err_o} !== 2'b00) begin
      failures++;
      $display("FAIL abort_quiet: ack=%b err=%b required 0 0", wbs_ack_o, wbs_err_o);
    end
    reg_rdata = 32'h0;
  endtask

  task automatic test_reset_mid();
    drive(32'h0000_0040, 1'b1, 4'hC, 32'h7777_8888);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wbs_dat_o, wbs_ack_o, wbs_err_o, reg_cs, reg_wr, reg_addr, reg_be, reg_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid: dat=%h ack=%b err=%b cs=%b wr=%b addr=%h be=%h wdata=%h required all 0",
               wbs_dat_o, wbs_ack_o, wbs_err_o, reg_cs, reg_wr, reg_addr, reg_be, reg_wdata);
    end
    rst = 1'b0;
    idle_bus();
    @(negedge clk);
    push_exp(1'b0, 32'd0);
    reg_rdata = 32'hFFFF_0000;
    drive(32'h0000_0044, 1'b1, 4'h6, 32'h1122_3344);
    @(negedge clk);
    checks++;
    if ({reg_cs, reg_wr, reg_addr, reg_be, reg_wdata} !== {1'b1, 1'b1, 24'h000044, 4'h6, 32'h1122_3344}) begin
      failures++;
      $display("FAIL post_reset_req: cs=%b wr=%b addr=%h be=%h wdata=%h required 1 1 000044 6 11223344",
               reg_cs, reg_wr, reg_addr, reg_be, reg_wdata);
    end
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ack: ack=%b required 1", wbs_ack_o);
    end
    idle_bus();
    reg_rdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd[3];
    logic [31:0] ad[3];
    int          ack_at[3];
    rd[0] = 32'hDA7A_0001; rd[1] = 32'hDA7A_0202; rd[2] = 32'hDA7A_3003;
    ad[0] = 32'h0000_0100; ad[1] = 32'h0000_0104; ad[2] = 32'h00FF_FFFC;
    for (int i = 0; i < 3; i++) push_exp(1'b0, rd[i]);
    drive(ad[0], 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({reg_cs, reg_addr} !== {1'b1, ad[i][AW-1:0]}) begin
        failures++;
        $display("FAIL b2b_req%0d: cs=%b addr=%h required 1 %h", i, reg_cs, reg_addr, ad[i][AW-1:0]);
      end
      reg_ack   = 1'b1;
      reg_rdata = rd[i];
      @(negedge clk);
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      ack_at[i] = cycle;
      checks++;
      if ({wbs_ack_o, wbs_dat_o} !== {1'b1, rd[i]}) begin
        failures++;
        $display("FAIL b2b_ack%0d: ack=%b dat=%h required 1 %h", i, wbs_ack_o, wbs_dat_o, rd[i]);
      end
      if (i < 2) begin
        adr = ad[i+1];
        @(negedge clk);
      end else begin
        idle_bus();
      end
    end
    checks++;
    if (ack_at[1] - ack_at[0] != 3 || ack_at[2] - ack_at[1] != 3) begin
      failures++;
      $display("FAIL b2b_spacing: gaps %0d %0d required 3 3",
               ack_at[1] - ack_at[0], ack_at[2] - ack_at[1]);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; wdat = '0; reg_rdata = '0; reg_ack = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d responses missing required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
